// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB device constants, TX buffer sizing and packet encodings
package usb_pkg;

  // TX payload buffer sizing
  localparam int TX_BUF_DEPTH = 64;
  localparam int TX_BUF_PTR_W = 6;
  localparam int TX_BUF_CNT_W = 7;

  // Packet request from the AHB slave to usb_tx
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SEND_DATA = 2'b01,
    NAK       = 2'b10,
    ACK       = 2'b11
  } tx_packet_t;

  // PID bytes as sent on the wire (PID nibble plus its complement check)
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // Occupancy after one cycle given which operations were actually performed
  function automatic logic [TX_BUF_CNT_W-1:0] next_count(
    input logic [TX_BUF_CNT_W-1:0] count,
    input logic                    push,
    input logic                    pop
  );
    logic [TX_BUF_CNT_W-1:0] result;
    result = count;
    case ({push, pop})
      2'b10:   result = count + TX_BUF_CNT_W'(1);
      2'b01:   result = count - TX_BUF_CNT_W'(1);
      default: result = count;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/usb_buf_ptr.sv
// rtl/usb_buf_ptr.sv - wrap-around buffer pointer with increment enable and synchronous clear
module usb_buf_ptr #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  // Last valid slot; the pointer returns to 0 after it so no slot is skipped
  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  // Pointer register: clear beats increment, wrap at the last slot
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == LAST) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/usb_tx_data_buffer.sv
// rtl/usb_tx_data_buffer.sv - FWFT bulk-IN payload FIFO; define USB_TX_BUF_STICKY_ERR_EN for sticky error flags
module usb_tx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = TX_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    store_tx_data,
  input  logic [7:0]              tx_data,
  input  logic                    get_tx_packet_data,
  output logic [7:0]              tx_packet_data,
  output logic [TX_BUF_CNT_W-1:0] buffer_occupancy,
  output logic                    buffer_full,
  output logic                    buffer_empty,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TX_BUF_CNT_W-1:0] FULL_CNT = TX_BUF_CNT_W'(DEPTH);

  logic [7:0]              mem [DEPTH];
  logic [PTR_W-1:0]        wptr;
  logic [PTR_W-1:0]        rptr;
  logic [TX_BUF_CNT_W-1:0] count;

  logic do_push;
  logic do_pop;
  logic overflow_evt;
  logic underflow_evt;

  assign buffer_occupancy = count;
  assign buffer_full      = (count == FULL_CNT);
  assign buffer_empty     = (count == '0);

  // Head byte falls through as soon as it is stored; an empty buffer reads as zero
  assign tx_packet_data = buffer_empty ? 8'h00 : mem[rptr];

  // Decide which strobes take effect: a pop frees the slot a simultaneous push
  // into a full buffer needs, but a push into an empty buffer cannot feed a pop
  // in the same cycle, so that pop is an underflow.
  always_comb begin
    do_push       = 1'b0;
    do_pop        = 1'b0;
    overflow_evt  = 1'b0;
    underflow_evt = 1'b0;
    if (!clear) begin
      do_pop        = get_tx_packet_data && !buffer_empty;
      underflow_evt = get_tx_packet_data && buffer_empty;
      do_push       = store_tx_data && (!buffer_full || get_tx_packet_data);
      overflow_evt  = store_tx_data && buffer_full && !get_tx_packet_data;
    end
  end

  // Payload storage; contents survive clear and reset, only pointers move
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= tx_data;
    end
  end

  usb_buf_ptr #(
    .WIDTH (PTR_W),
    .DEPTH (DEPTH)
  ) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (do_push),
    .ptr   (wptr)
  );

  usb_buf_ptr #(
    .WIDTH (PTR_W),
    .DEPTH (DEPTH)
  ) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (do_pop),
    .ptr   (rptr)
  );

  // Occupancy counter; it alone tells full from empty once pointers coincide
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= next_count(count, do_push, do_pop);
    end
  end

  // Error flags: either held until clear, or a one-cycle pulse after the offending edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
`ifdef USB_TX_BUF_STICKY_ERR_EN
      if (overflow_evt) begin
        overflow_err <= 1'b1;
      end
      if (underflow_evt) begin
        underflow_err <= 1'b1;
      end
`else
      overflow_err  <= overflow_evt;
      underflow_err <= underflow_evt;
`endif
    end
  end

endmodule
